mem_port_arbiter: RTL and testbench

- Shares the single external memory port between instruction fetch (I side) and data access (D side) of the mMips pipeline.
- Produces the `imem_wait` / `dmem_wait` stall signals consumed by the hazard detection unit.
- D side has priority; a bounded-starvation counter guarantees fetch progress.
- Sits between the IF/MEM stages and the memory bus.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-fetch and D-access; D has priority, a starvation counter forces I through.
// Latency: grant edge then mem_ready edge, one idle bubble between transactions; requesters stall on combinational wait.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_wait,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_wait,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IGNT = 2'd1,
    ST_DGNT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic [CNT_W-1:0]   w_starve_nxt;
  logic               r_i_done;
  logic               r_d_done;
  logic               r_mem_we;
  logic [BE_W-1:0]    r_mem_be;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [DATA_W-1:0]  r_i_rdata;
  logic [DATA_W-1:0]  r_d_rdata;

  logic w_i_elig;
  logic w_d_elig;
  logic w_bubble;
  logic w_grant_i;
  logic w_grant_d;
  logic w_complete;

  assign w_i_elig = i_req & ~r_i_done;
  assign w_d_elig = d_req & ~r_d_done;
  // A done flag is only ever set in the cycle right after a completion; that cycle is the idle bubble.
  assign w_bubble = r_i_done | r_d_done;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && !w_bubble) begin
          if (w_d_elig && (!w_i_elig || (r_starve_cnt < STARVE_LIM))) begin
            w_grant_d   = 1'b1;
            w_state_nxt = ST_DGNT;
          end else if (w_i_elig) begin
            w_grant_i   = 1'b1;
            w_state_nxt = ST_IGNT;
          end
        end
      end
      ST_IGNT, ST_DGNT: begin
        if (mem_ready) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_grant_i) begin
      w_starve_nxt = '0;
    end else if (w_grant_d && i_req) begin
      if (r_starve_cnt != STARVE_LIM) begin
        w_starve_nxt = r_starve_cnt + CNT_W'(1);
      end
    end else if ((r_state == ST_IDLE) && !i_req) begin
      w_starve_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_i_done     <= 1'b0;
      r_d_done     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_i_done     <= w_complete && (r_state == ST_IGNT);
      r_d_done     <= w_complete && (r_state == ST_DGNT);
    end
  end

  // Memory-side request fields are frozen from the grant edge until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant_d) begin
      r_mem_we    <= d_we;
      r_mem_be    <= d_be;
      r_mem_addr  <= d_addr;
      r_mem_wdata <= d_wdata;
    end else if (w_grant_i) begin
      r_mem_we    <= 1'b0;
      r_mem_be    <= '1;
      r_mem_addr  <= i_addr;
      r_mem_wdata <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else if (w_complete) begin
      if (r_state == ST_IGNT) begin
        r_i_rdata <= mem_rdata;
      end else if (!r_mem_we) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  assign mem_req   = (r_state != ST_IDLE);
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_wait    = i_req & ~r_i_done;
  assign d_wait    = d_req & ~r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random two-sided traffic
// checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_wait;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [BW-1:0] d_be = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_wait;
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_wait(i_wait),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_wait(d_wait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    if (a == 32'h0040_0000) return 32'h2408_0005;
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  // Memory responder: pulses mem_ready resp_delay cycles after the grant cycle begins.
  bit resp_en = 1'b1;
  bit resp_rand = 1'b0;
  int resp_delay = 0;
  int resp_cnt = 0;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (resp_en && mem_req) begin
        if (resp_cnt >= resp_delay) begin
          mem_ready = 1'b1;
          mem_rdata = mem_model(mem_addr);
          resp_cnt  = 0;
          if (resp_rand) resp_delay = $urandom_range(0, 3);
        end else begin
          resp_cnt++;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // Reference model: one transaction at a time, a free cycle after each completion,
  // D preferred unless I has already waited out SM D grants.
  logic          m_busy, m_bubble, m_side_d, m_we, m_idone, m_ddone;
  int            m_cnt;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_wdata, m_irdata, m_drdata;
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_busy = 0; m_bubble = 0; m_side_d = 0; m_we = 0; m_idone = 0; m_ddone = 0;
        m_cnt = 0; m_addr = '0; m_be = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
      end else begin
        m_idone = 0;
        m_ddone = 0;
        if (m_busy) begin
          if (mem_ready) begin
            m_busy = 0;
            m_bubble = 1;
            if (m_side_d) begin
              m_ddone = 1;
              if (!m_we) m_drdata = mem_model(m_addr);
            end else begin
              m_idone = 1;
              m_irdata = mem_model(m_addr);
            end
          end
        end else begin
          if (!i_req) m_cnt = 0;
          if (m_bubble) begin
            m_bubble = 0;
          end else if (enable && (d_req || i_req)) begin
            m_busy = 1;
            if (d_req && (!i_req || m_cnt < SM)) begin
              m_side_d = 1; m_addr = d_addr; m_we = d_we; m_be = d_be; m_wdata = d_wdata;
              if (i_req) m_cnt++;
            end else begin
              m_side_d = 0; m_addr = i_addr; m_we = 0; m_be = '1; m_wdata = '0;
              m_cnt = 0;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    bit idle_seen;
    idle_seen = 1'b0;
    tick();
    i_req = 0; d_req = 0; d_we = 0; enable = 1; resp_en = 1; resp_delay = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!mem_req) begin idle_seen = 1'b1; break; end
    end
    n_checks++;
    if (!idle_seen) begin n_fails++; $display("FAIL quiet_idle: mem_req still %b, want 0", mem_req); end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 0; enable = 1; i_req = 1; d_req = 1; d_we = 0; d_be = '1;
    i_addr = 32'h0040_0100; d_addr = 32'h1000_0100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fails++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_checks++; if (i_wait !== 1'b1) begin n_fails++; $display("FAIL reset_i_wait: got %b want 1", i_wait); end
    n_checks++; if (d_wait !== 1'b1) begin n_fails++; $display("FAIL reset_d_wait: got %b want 1", d_wait); end
    n_checks++; if (i_rdata !== '0) begin n_fails++; $display("FAIL reset_i_rdata: got %h want 0", i_rdata); end
    n_checks++; if (d_rdata !== '0) begin n_fails++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
    n_checks++;
    if ({mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      n_fails++; $display("FAIL reset_mem_bus: got we=%b be=%h addr=%h wdata=%h want all 0", mem_we, mem_be, mem_addr, mem_wdata);
    end
    rst = 1;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) begin n_fails++; $display("FAIL reset_first_grant: mem_req %b want 1", mem_req); end
    n_checks++; if (mem_addr !== d_addr) begin n_fails++; $display("FAIL reset_first_side: addr %h want %h (D)", mem_addr, d_addr); end
    quiet();
  endtask

  task automatic test_single_fetch();
    int  high_cnt;
    bit  low_seen, gchk;
    high_cnt = 0; low_seen = 0; gchk = 0;
    resp_delay = 3;
    i_addr = 32'h0040_0000; i_req = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mem_req && !gchk) begin
        gchk = 1;
        n_checks++; if (mem_addr !== 32'h0040_0000) begin n_fails++; $display("FAIL fetch_addr: got %h want 00400000", mem_addr); end
        n_checks++; if (mem_we !== 1'b0) begin n_fails++; $display("FAIL fetch_we: got %b want 0", mem_we); end
        n_checks++; if (mem_be !== 4'hF) begin n_fails++; $display("FAIL fetch_be: got %h want f", mem_be); end
      end
      if (i_wait) high_cnt++;
      else begin low_seen = 1; break; end
    end
    n_checks++; if (!low_seen) begin n_fails++; $display("FAIL fetch_timeout: i_wait never low"); end
    n_checks++; if (high_cnt != 5) begin n_fails++; $display("FAIL fetch_latency: %0d stall cycles want 5", high_cnt); end
    n_checks++; if (i_rdata !== 32'h2408_0005) begin n_fails++; $display("FAIL fetch_rdata: got %h want 24080005", i_rdata); end
    @(negedge clk);
    n_checks++; if (i_wait !== 1'b1) begin n_fails++; $display("FAIL fetch_wait_pulse: i_wait %b want 1 (low only one cycle)", i_wait); end
    quiet();
  endtask

  task automatic test_store();
    int rdy_k, low_k;
    bit gchk;
    logic [DW-1:0] exp_d;
    rdy_k = -10; low_k = -1; gchk = 0;
    exp_d = mem_model(32'h1000_0100);
    resp_delay = 1;
    d_we = 1; d_be = 4'b0011; d_addr = 32'h1000_0004; d_wdata = 32'hDEAD_BEEF; d_req = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mem_req && !gchk) begin
        gchk = 1;
        n_checks++; if (mem_we !== 1'b1) begin n_fails++; $display("FAIL store_we: got %b want 1", mem_we); end
        n_checks++; if (mem_be !== 4'b0011) begin n_fails++; $display("FAIL store_be: got %b want 0011", mem_be); end
        n_checks++; if (mem_addr !== 32'h1000_0004) begin n_fails++; $display("FAIL store_addr: got %h want 10000004", mem_addr); end
        n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fails++; $display("FAIL store_wdata: got %h want deadbeef", mem_wdata); end
      end
      if (mem_ready) rdy_k = k;
      if (!d_wait) begin low_k = k; break; end
    end
    n_checks++; if (low_k != rdy_k + 1) begin n_fails++; $display("FAIL store_wait_timing: wait low at %0d, ready at %0d", low_k, rdy_k); end
    n_checks++; if (d_rdata !== exp_d) begin n_fails++; $display("FAIL store_d_rdata: got %h want %h (unchanged)", d_rdata, exp_d); end
    quiet();
  endtask

  task automatic test_priority();
    logic [9:0] exp_seq;
    int g;
    bit prev;
    exp_seq = 10'b0111101111;
    g = 0; prev = 0;
    resp_delay = 0;
    i_addr = 32'h0040_0200; d_addr = 32'h1000_0200; d_we = 0;
    i_req = 1; d_req = 1;
    for (int k = 0; k < 200 && g < 10; k++) begin
      @(negedge clk);
      if (mem_req && !prev) begin
        n_checks++;
        if ((mem_addr == d_addr) !== exp_seq[g]) begin
          n_fails++; $display("FAIL priority_grant%0d: got D=%b want D=%b", g, mem_addr == d_addr, exp_seq[g]);
        end
        g++;
      end
      prev = mem_req;
    end
    n_checks++; if (g != 10) begin n_fails++; $display("FAIL priority_count: %0d grants want 10", g); end
    quiet();
  endtask

  task automatic test_enable_drop();
    bit seen, bad;
    seen = 0; bad = 0;
    resp_delay = 2;
    d_we = 0; d_addr = 32'h1000_0300; d_req = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1; break; end
    end
    n_checks++; if (!seen) begin n_fails++; $display("FAIL en_grant: no grant seen"); end
    tick();
    enable = 0; i_addr = 32'h0040_0300; i_req = 1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!d_wait) begin seen = 1; break; end
    end
    n_checks++; if (!seen) begin n_fails++; $display("FAIL en_complete: d_wait never low"); end
    n_checks++;
    if (d_rdata !== mem_model(32'h1000_0300)) begin
      n_fails++; $display("FAIL en_d_rdata: got %h want %h", d_rdata, mem_model(32'h1000_0300));
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_req) bad = 1;
    end
    n_checks++; if (bad) begin n_fails++; $display("FAIL en_blocked: mem_req 1 while enable=0, want 0"); end
    tick();
    enable = 1;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fails++; $display("FAIL en_resume_early: mem_req %b want 0", mem_req); end
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1) begin n_fails++; $display("FAIL en_resume: mem_req %b want 1", mem_req); end
    n_checks++; if (mem_addr !== d_addr) begin n_fails++; $display("FAIL en_resume_side: addr %h want %h", mem_addr, d_addr); end
    quiet();
  endtask

  task automatic test_async_reset();
    logic [4:0] exp_seq;
    int g;
    bit prev;
    exp_seq = 5'b01111;
    g = 0; prev = 0;
    resp_delay = 0;
    i_addr = 32'h0040_0400; d_addr = 32'h1000_0400; d_we = 0;
    i_req = 1; d_req = 1;
    for (int k = 0; k < 200 && g < 4; k++) begin
      @(negedge clk);
      if (mem_req && !prev) begin
        g++;
        if (g == 3) resp_en = 0;
      end
      prev = mem_req;
    end
    n_checks++; if (g != 4 || mem_addr !== d_addr) begin n_fails++; $display("FAIL arst_setup: %0d grants, addr %h want 4 and %h", g, mem_addr, d_addr); end
    #2;
    rst = 0;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fails++; $display("FAIL arst_mem_req: got %b want 0 before edge", mem_req); end
    n_checks++; if (mem_addr !== '0) begin n_fails++; $display("FAIL arst_mem_addr: got %h want 0", mem_addr); end
    n_checks++; if (d_rdata !== '0 || i_rdata !== '0) begin n_fails++; $display("FAIL arst_rdata: i %h d %h want 0", i_rdata, d_rdata); end
    n_checks++; if (d_wait !== 1'b1 || i_wait !== 1'b1) begin n_fails++; $display("FAIL arst_wait: i %b d %b want 1 1", i_wait, d_wait); end
    tick(); tick();
    rst = 1; resp_en = 1;
    g = 0; prev = 0;
    for (int k = 0; k < 200 && g < 5; k++) begin
      @(negedge clk);
      if (mem_req && !prev) begin
        n_checks++;
        if ((mem_addr == d_addr) !== exp_seq[g]) begin
          n_fails++; $display("FAIL arst_grant%0d: got D=%b want D=%b", g, mem_addr == d_addr, exp_seq[g]);
        end
        g++;
      end
      prev = mem_req;
    end
    n_checks++; if (g != 5) begin n_fails++; $display("FAIL arst_count: %0d grants want 5", g); end
    quiet();
  endtask

  task automatic test_random_traffic();
    bit rnd_on, i_ok, d_ok, d_abandon;
    int i_idle, d_idle, d_lim;
    rnd_on = 1;
    resp_rand = 1; resp_delay = 1;
    fork
      begin
        for (int k = 0; k < 600; k++) begin
          @(negedge clk);
          n_checks++; if (mem_req !== m_busy) begin n_fails++; $display("FAIL rnd_mem_req@%0d: got %b want %b", k, mem_req, m_busy); end
          if (m_busy) begin
            n_checks++; if (mem_addr !== m_addr) begin n_fails++; $display("FAIL rnd_addr@%0d: got %h want %h", k, mem_addr, m_addr); end
            n_checks++; if (mem_we !== m_we) begin n_fails++; $display("FAIL rnd_we@%0d: got %b want %b", k, mem_we, m_we); end
            n_checks++; if (mem_be !== m_be) begin n_fails++; $display("FAIL rnd_be@%0d: got %h want %h", k, mem_be, m_be); end
            n_checks++; if (mem_wdata !== m_wdata) begin n_fails++; $display("FAIL rnd_wdata@%0d: got %h want %h", k, mem_wdata, m_wdata); end
          end
          n_checks++; if (i_wait !== (i_req & ~m_idone)) begin n_fails++; $display("FAIL rnd_i_wait@%0d: got %b want %b", k, i_wait, i_req & ~m_idone); end
          n_checks++; if (d_wait !== (d_req & ~m_ddone)) begin n_fails++; $display("FAIL rnd_d_wait@%0d: got %b want %b", k, d_wait, d_req & ~m_ddone); end
          n_checks++; if (i_rdata !== m_irdata) begin n_fails++; $display("FAIL rnd_i_rdata@%0d: got %h want %h", k, i_rdata, m_irdata); end
          n_checks++; if (d_rdata !== m_drdata) begin n_fails++; $display("FAIL rnd_d_rdata@%0d: got %h want %h", k, d_rdata, m_drdata); end
        end
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          i_idle = $urandom_range(0, 3);
          repeat (i_idle) tick();
          if (!rnd_on) break;
          i_addr = 32'h0040_0000 | ($urandom & 32'h000F_FFFC);
          i_req = 1;
          i_ok = 0;
          for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (!i_wait) begin i_ok = 1; break; end
          end
          if (!i_ok) begin n_checks++; n_fails++; $display("FAIL rnd_i_timeout: fetch never completed"); end
          tick();
          i_req = 0;
        end
      end
      begin
        while (rnd_on) begin
          d_idle = $urandom_range(0, 3);
          repeat (d_idle) tick();
          if (!rnd_on) break;
          d_addr = 32'h1000_0000 | ($urandom & 32'h000F_FFFC);
          d_we = 1'($urandom_range(0, 1));
          d_be = 4'($urandom_range(0, 15));
          d_wdata = $urandom;
          d_abandon = ($urandom_range(0, 7) == 0);
          d_lim = d_abandon ? $urandom_range(1, 4) : 300;
          d_req = 1;
          d_ok = 0;
          for (int w = 0; w < d_lim; w++) begin
            @(negedge clk);
            if (!d_wait) begin d_ok = 1; break; end
          end
          if (!d_ok && !d_abandon) begin n_checks++; n_fails++; $display("FAIL rnd_d_timeout: data access never completed"); end
          tick();
          d_req = 0;
        end
      end
      begin
        while (rnd_on) begin
          tick();
          enable = ($urandom_range(0, 9) != 0);
        end
        enable = 1;
      end
    join
    resp_rand = 0;
    quiet();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_priority();
    test_enable_drop();
    test_async_reset();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
